if_stage: RTL
=============

// Module: if_stage
// PURPOSE
//  Instruction-fetch stage of the 16-bit pipelined CPU. Owns the PC, drives the word address
//  into imem (combinational read) and registers the returned op into the IF/ID pipeline register.
//  Takes stall from the hazard unit and branch/jump redirects from decode.
//  Branches have one architectural delay slot, so a redirect never flushes.
//  Detects the jump-to-self idiom (JMP 11'h7ff) and halts fetch.
// PARAMETERS
//  PC_W      16      PC / imem address width; the PC is a word index.
//  RESET_PC  16'h0   PC value loaded during reset.
//  NOP_OP    16'h0   Op inserted into IF/ID as a bubble.
// PORTS
//  clk            in   1     clock
//  rst_n          in   1     synchronous, active-low reset
//  stall_i        in   1     hazard unit: hold PC and IF/ID this cycle
//  redirect_i     in   1     decode: taken branch/jump resolved this cycle
//  redirect_pc_i  in   PC_W  decode: target word address
//  imem_op_i      in   16    op read from imem at imem_pc_o (same cycle)
//  imem_pc_o      out  PC_W  current PC, to imem
//  if_op_o        out  16    IF/ID op
//  if_pc_o        out  PC_W  IF/ID address of if_op_o
//  if_npc_o       out  PC_W  IF/ID if_pc_o+1, base for decode's relative targets
//  if_valid_o     out  1     IF/ID holds a real instruction
//  halted_o       out  1     fetch permanently stopped (jump-to-self seen)
//  fetch_cnt_o    out  16    count of instructions loaded into IF/ID
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge): PC=RESET_PC, if_op=NOP_OP, if_pc=if_npc=0, if_valid=0,
//   halted=0, fetch_cnt=0, state=RUN. imem is being initialised in these same cycles.
//   Fetch therefore starts on the first edge with rst_n=1: IF/ID<=imem[RESET_PC].
//   Reset mid-run takes effect on that edge and discards everything in flight.
//  FSM states: RUN, HALT.
//  RUN, per edge, priority top-down:
//   - stall_i=1: PC, IF/ID and fetch_cnt hold; redirect_i is ignored.
//     Decode holds the branch and re-asserts redirect on the next unstalled cycle.
//   - redirect_i=1: IF/ID<={imem_op_i, PC, PC+1, valid=1}; this is the delay slot.
//     PC<=redirect_pc_i; fetch_cnt+=1.
//   - else: IF/ID<={imem_op_i, PC, PC+1, 1}; PC<=PC+1; fetch_cnt+=1.
//  Halt: in RUN, if redirect_i && !stall_i && redirect_pc_i==if_pc_o (branch targets itself):
//   - the delay slot is captured as normal, PC<=redirect_pc_i, state<=HALT.
//  HALT: PC frozen; IF/ID<={NOP_OP, if_pc_o, if_npc_o, 0} every edge; halted_o=1.
//   stall_i and redirect_i are ignored; only reset leaves HALT.
//  Arithmetic: PC+1 is modulo 2^PC_W (0xFFFF wraps to 0x0000); fetch_cnt wraps 0xFFFF->0.
//  Timing: imem_pc_o=PC is a register output. The op reaches if_op_o one edge after the PC is presented.
//  No combinational path from any input to imem_pc_o.
// STRUCTURE
//  Shared def.h holds the opcodes (OP_JMP etc.), NOP_OP and the state encodings.
//  Single module: a PC register, the IF/ID register, a 1-bit FSM and the counter.
//  No sub-module needed.
// TESTING
//  1 Reset 3 cycles, release -> cycle1 if_op=imem[0], if_pc=0, if_npc=1, valid=1.
//    By cycle4 if_pc=3 and fetch_cnt=4.
//  2 PC=5, stall_i=1 for 2 cycles -> imem_pc_o stays 5 and IF/ID unchanged.
//    After release if_pc=5 and cnt increments once per cycle.
//  3 Branch at 35 in ID, PC=36, redirect_pc=38 -> next if_pc=36 (delay slot) with valid=1.
//    The following if_pc=38.
//  4 stall_i=1 and redirect_i=1 together (PC=40, target 30) -> PC stays 40.
//    Next cycle redirect alone -> delay slot 40 captured, then PC=30.
//  5 JMP at 60, redirect_pc=60 while if_pc=60 -> delay slot 61 captured.
//    Then valid=0, halted=1, imem_pc_o=60 for 20 cycles despite redirect pulses.
//  6 Reset asserted while halted or mid-stall -> all outputs return to reset values.
//    PC=0 and fetch restarts.
//    Also: force PC to 16'hFFFF -> next PC=0.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared definitions for the fetch stage: default widths, bubble op, jump opcode and FSM encoding.
package if_stage_pkg;

  localparam int          PC_W_DEF   = 16;
  localparam logic [15:0] NOP_OP_DEF = 16'h0000;

  // JMP occupies the top 5 bits; an 11-bit offset of all ones is the jump-to-self idiom.
  localparam logic [4:0]  OP_JMP     = 5'b11111;
  localparam logic [15:0] JMP_SELF   = {OP_JMP, 11'h7ff};

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage bus: hazard/decode control in, imem address/data, IF/ID register contents out.
interface if_stage_if
  import if_stage_pkg::*;
#(
  parameter int PC_W = PC_W_DEF
);

  logic            stall_i;
  logic            redirect_i;
  logic [PC_W-1:0] redirect_pc_i;
  logic [15:0]     imem_op_i;
  logic [PC_W-1:0] imem_pc_o;
  logic [15:0]     if_op_o;
  logic [PC_W-1:0] if_pc_o;
  logic [PC_W-1:0] if_npc_o;
  logic            if_valid_o;
  logic            halted_o;
  logic [15:0]     fetch_cnt_o;

  modport master (
    input  stall_i, redirect_i, redirect_pc_i, imem_op_i,
    output imem_pc_o, if_op_o, if_pc_o, if_npc_o, if_valid_o, halted_o, fetch_cnt_o
  );

  modport slave (
    output stall_i, redirect_i, redirect_pc_i, imem_op_i,
    input  imem_pc_o, if_op_o, if_pc_o, if_npc_o, if_valid_o, halted_o, fetch_cnt_o
  );

endinterface

// File: rtl/if_stage.sv
// Instruction fetch: PC register feeds imem, op lands in IF/ID one edge later; stall holds everything.
// Redirects take effect after a single delay slot; a branch to its own address halts fetch until reset.
module if_stage
  import if_stage_pkg::*;
#(
  parameter int              PC_W     = PC_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [15:0]     NOP_OP   = NOP_OP_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  if_stage_if.master bus
);

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pc_inc;
  logic [15:0]     op_q, op_d;
  logic [PC_W-1:0] ifpc_q, ifpc_d;
  logic [PC_W-1:0] ifnpc_q, ifnpc_d;
  logic            valid_q, valid_d;
  logic [15:0]     cnt_q, cnt_d;

  assign pc_inc = pc_q + {{(PC_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      op_q    <= NOP_OP;
      ifpc_q  <= '0;
      ifnpc_q <= '0;
      valid_q <= 1'b0;
      cnt_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      op_q    <= op_d;
      ifpc_q  <= ifpc_d;
      ifnpc_q <= ifnpc_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    op_d    = op_q;
    ifpc_d  = ifpc_q;
    ifnpc_d = ifnpc_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      ST_RUN: begin
        // A stalled cycle drops any redirect; decode re-presents it once unstalled.
        if (!bus.stall_i) begin
          op_d    = bus.imem_op_i;
          ifpc_d  = pc_q;
          ifnpc_d = pc_inc;
          valid_d = 1'b1;
          cnt_d   = cnt_q + 16'd1;
          if (bus.redirect_i) begin
            pc_d = bus.redirect_pc_i;
            if (bus.redirect_pc_i == ifpc_q) begin
              state_d = ST_HALT;
            end
          end else begin
            pc_d = pc_inc;
          end
        end
      end
      ST_HALT: begin
        // Keep the last address visible but present bubbles forever.
        op_d    = NOP_OP;
        valid_d = 1'b0;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  assign bus.imem_pc_o   = pc_q;
  assign bus.if_op_o     = op_q;
  assign bus.if_pc_o     = ifpc_q;
  assign bus.if_npc_o    = ifnpc_q;
  assign bus.if_valid_o  = valid_q;
  assign bus.halted_o    = (state_q == ST_HALT);
  assign bus.fetch_cnt_o = cnt_q;

endmodule
